hilo_mult_controller: RTL and testbench

Multi-cycle sequencer for the Hi/Lo multiply path (MULT, MULTU, MADD, MSUB, MTHI, MTLO). It replaces the single-cycle 64-bit multiply in the ALU with an iterative radix-2 shift-add engine, and owns the architectural Hi/Lo registers. It tells the pipeline when to stall: on a new multiply while one is in flight, and on MFHI/MFLO while a result is pending. It sits beside the EX-stage ALU; the ALU's move-from-Hi/Lo operations read this block's Hi/Lo outputs.

---
 rtl/hilo_mult_if.sv | 16 +
 rtl/hilo_mult_controller.sv | 110 +++++++++++
 tb/tb_hilo_mult_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hilo_mult_if.sv
// hilo_mult_if: issue/result bundle between the EX stage and the Hi/Lo multiply sequencer
// Ports: Start/Op/A/B/ReadHiLo from the pipeline (master), Busy/Stall/Done/Hi/Lo from the sequencer (slave)
interface hilo_mult_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ReadHiLo;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  modport master (output Start, Op, A, B, ReadHiLo, input Busy, Stall, Done, Hi, Lo);
  modport slave (input Start, Op, A, B, ReadHiLo, output Busy, Stall, Done, Hi, Lo);
endinterface

// File: rtl/hilo_mult_controller.sv
// hilo_mult_controller: radix-2 shift-add MULT/MULTU/MADD/MSUB sequencer owning Hi/Lo, plus MTHI/MTLO
// Ports: Clk, Reset (sync, active-high); bus (hilo_mult_if.slave): Start, Op, A, B, ReadHiLo in; Busy, Stall, Done, Hi, Lo out
// Option: define MULT_EARLY_EXIT_EN to leave MUL as soon as the remaining multiplier is zero
module hilo_mult_controller #(
  parameter int WIDTH = 32
) (
  input logic        Clk,
  input logic        Reset,
  hilo_mult_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mplier_q, mplier_d;
  logic [W2-1:0]    mcand_q, mcand_d, prod_q, prod_d, saved_q, saved_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             sign_q, sign_d, done_q, done_d;
  logic             is_mul, is_signed, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]    p, fix_val;
  always_comb begin
    is_mul    = !bus.Op[2];
    is_signed = bus.Op != 3'd1;
    // 0x80..0 negates to itself and is then read as an unsigned magnitude
    mag_a     = (is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    mag_b     = (is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    p         = sign_q ? -prod_q : prod_q;
    fix_val   = op_q == 3'd2 ? saved_q + p : op_q == 3'd3 ? saved_q - p : p;
`ifdef MULT_EARLY_EXIT_EN
    last_iter = (cnt_q == CW'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
    last_iter = cnt_q == CW'(WIDTH - 1);
`endif
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sign_d    = sign_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start && is_mul) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          sign_d   = is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          op_d     = bus.Op;
          saved_d  = {hi_q, lo_q};
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = MUL;
        end else if (bus.Start) begin
          hi_d = bus.Op == 3'd4 ? bus.A : hi_q;
          lo_d = bus.Op == 3'd5 ? bus.A : lo_q;
        end
      end
      MUL: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = last_iter ? FIX : MUL;
      end
      FIX: begin
        {hi_d, lo_d} = fix_val;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      saved_q  <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      saved_q  <= saved_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end
  assign bus.Busy  = state_q != IDLE;
  assign bus.Stall = bus.Busy & (bus.Start | bus.ReadHiLo);
  assign bus.Done  = done_q;
  assign bus.Hi    = hi_q;
  assign bus.Lo    = lo_q;
endmodule

// File: tb/tb_hilo_mult_controller.sv
// tb_hilo_mult_controller: vector table plus scoreboard bench for hilo_mult_controller
module tb_hilo_mult_controller;
  localparam int W = 32;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];
  logic [63:0] hilo_m;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vt[13];
  hilo_mult_if #(.WIDTH(W)) bus ();
  hilo_mult_controller #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl);
    logic [63:0] sa = {{32{a[31]}}, a};
    logic [63:0] sbv = {{32{b[31]}}, b};
    logic [63:0] pr = op == 3'd1 ? {32'b0, a} * {32'b0, b} : sa * sbv;
    return op == 3'd2 ? hl + pr : op == 3'd3 ? hl - pr : pr;
  endfunction
  function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m = (op != 3'd1 && b[31]) ? -b : b;
    int n = 1;
    for (int k = 0; k < 32; k++) if (m[k]) n = k + 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction
  always @(negedge Clk) begin
    if (bus.Done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got Done=1 expected no pending result");
      end else begin
        chk("sb_result", {bus.Hi, bus.Lo}, sb.pop_front());
      end
    end
  end
  task automatic run_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    int n = 0;
    bus.Start = 1'b1;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    if (op < 3'd4) sb.push_back(e);
    @(negedge Clk);
    bus.Start = 1'b0;
    if (op < 3'd4) begin
      while (bus.Busy && n < 200) begin
        n++;
        @(negedge Clk);
      end
      chk("busy_cycles", 64'(n), 64'(exp_busy(op, b)));
      chk("done_pulse", {63'b0, bus.Done}, 64'd1);
    end else begin
      chk("no_busy", {63'b0, bus.Busy}, 64'd0);
    end
    chk("hilo", {bus.Hi, bus.Lo}, e);
    hilo_m = e;
  endtask
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    logic [63:0] e;
    int n;
    vt[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vt[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
    vt[2]  = '{3'd2, 32'h00000002, 32'h00000003, 64'hFFFFFFFF_FFFFFFF1};
    vt[3]  = '{3'd4, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFF1};
    vt[4]  = '{3'd5, 32'h00000009, 32'h00000000, 64'h00000005_00000009};
    vt[5]  = '{3'd3, 32'h80000000, 32'h00000002, 64'h00000006_00000009};
    vt[6]  = '{3'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vt[7]  = '{3'd1, 32'h00001234, 32'h00000001, 64'h00000000_00001234};
    vt[8]  = '{3'd1, 32'h00001234, 32'h00000000, 64'h00000000_00000000};
    vt[9]  = '{3'd3, 32'h00000007, 32'hFFFFFFFF, 64'h00000000_00000007};
    vt[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000008};
    vt[11] = '{3'd1, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
    vt[12] = '{3'd6, 32'h0000DEAD, 32'h0000BEEF, 64'h00000001_00000000};
    bus.Start = 1'b0;
    bus.Op = 3'd0;
    bus.A = '0;
    bus.B = '0;
    bus.ReadHiLo = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
    chk("reset_flags", {61'b0, bus.Busy, bus.Done, bus.Stall}, 64'd0);
    Reset = 1'b0;
    hilo_m = '0;
    for (int i = 0; i < 13; i++) run_vec(vt[i].op, vt[i].a, vt[i].b, vt[i].exp);
    repeat (6) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      e = model(op, a, b, hilo_m);
      run_vec(op, a, b, e);
    end
    e = model(3'd0, 32'd3, 32'd5, hilo_m);
    bus.Start = 1'b1;
    bus.Op = 3'd0;
    bus.A = 32'd3;
    bus.B = 32'd5;
    sb.push_back(e);
    @(negedge Clk);
    bus.Op = 3'd4;
    bus.A = 32'h0000DEAD;
    bus.ReadHiLo = 1'b1;
    n = 0;
    while (bus.Busy && n < 200) begin
      chk("stall_busy", {63'b0, bus.Stall}, 64'd1);
      chk("hilo_held", {bus.Hi, bus.Lo}, hilo_m);
      n++;
      @(negedge Clk);
    end
    chk("stall_done_cycle", {63'b0, bus.Stall}, 64'd0);
    bus.Start = 1'b0;
    bus.ReadHiLo = 1'b0;
    chk("stall_result", {bus.Hi, bus.Lo}, e);
    hilo_m = e;
    @(negedge Clk);
    chk("second_start_dropped", {bus.Hi, bus.Lo}, e);
    bus.Start = 1'b1;
    bus.Op = 3'd1;
    bus.A = 32'd7;
    bus.B = 32'hFFFFFFFF;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge Clk);
    chk("busy_before_reset", {63'b0, bus.Busy}, 64'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_hilo", {bus.Hi, bus.Lo}, 64'd0);
    chk("abort_flags", {62'b0, bus.Busy, bus.Done}, 64'd0);
    repeat (40) @(negedge Clk);
    chk("abort_idle", {bus.Hi, bus.Lo, 63'b0, bus.Busy} != 0 ? 64'd1 : 64'd0, 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
